// File: rtl/mem_line_bridge_if.sv
// Request/response line types and the bus interface shared by mem_line_bridge and its L1/memory neighbours.
package mem_line_bridge_pkg;
  localparam int LINE_BITS      = 512;
  localparam int LINE_ADDR_BITS = 64 - $clog2(LINE_BITS / 8);

  typedef struct packed {
    logic                      mem_req_load;
    logic                      mem_req_store;
    logic [LINE_ADDR_BITS-1:0] mem_addr;
    logic [LINE_BITS-1:0]      mem_data_out;
  } mem_bus_req_t;

  typedef struct packed {
    logic                 mem_ready;
    logic [LINE_BITS-1:0] mem_data;
  } mem_bus_resp_t;
endpackage

interface mem_line_bridge_if #(
  parameter int WIDTH = 64
);
  import mem_line_bridge_pkg::*;

  mem_bus_req_t     req;
  mem_bus_resp_t    resp;
  logic             bm_valid;
  logic             bm_we;
  logic [63:0]      bm_addr;
  logic [WIDTH-1:0] bm_wdata;
  logic             bm_ready;
  logic             bm_rvalid;
  logic [WIDTH-1:0] bm_rdata;

  // master is the bridge: it consumes L1 requests and drives the beat port.
  modport master (
    input  req,
    output resp,
    output bm_valid, bm_we, bm_addr, bm_wdata,
    input  bm_ready, bm_rvalid, bm_rdata
  );

  modport slave (
    output req,
    input  resp,
    input  bm_valid, bm_we, bm_addr, bm_wdata,
    output bm_ready, bm_rvalid, bm_rdata
  );
endinterface

// File: rtl/mem_line_bridge.sv
// Serialises L1 line refills/writebacks into WIDTH-bit beats on a single-outstanding memory port.
// Optional LINE_BRIDGE_PERF_EN adds load/store/stall performance counters.
module mem_line_bridge
  import mem_line_bridge_pkg::*;
#(
  parameter int CACHE_LINE_SIZE = LINE_BITS,
  parameter int WIDTH           = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  mem_line_bridge_if.master bus
`ifdef LINE_BRIDGE_PERF_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_stall
`endif
);
  localparam int BEATS       = CACHE_LINE_SIZE / WIDTH;
  localparam int OFFSET_BITS = $clog2(CACHE_LINE_SIZE / 8);
  localparam int BEAT_BITS   = $clog2(BEATS);
  localparam int BYTE_BITS   = OFFSET_BITS - BEAT_BITS;
  localparam int LINE_ADDR_W = 64 - OFFSET_BITS;
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, WR_BEAT, RD_REQ, RD_WAIT, RESP} state_t;

  state_t                     state;
  logic [BEAT_BITS-1:0]       beat_cnt;
  logic [BEAT_BITS-1:0]       next_beat;
  logic [LINE_ADDR_W-1:0]     line_addr;
  logic [CACHE_LINE_SIZE-1:0] line_buf;
  logic                       beat_valid;
  logic                       beat_we;
  logic [63:0]                beat_addr;
  logic [WIDTH-1:0]           beat_wdata;
  logic                       ready_pulse;
  logic [CACHE_LINE_SIZE-1:0] resp_line;
  logic                       accept;

  assign next_beat     = beat_cnt + 1'b1;
  assign accept        = beat_valid && bus.bm_ready;
  assign bus.bm_valid  = beat_valid;
  assign bus.bm_we     = beat_we;
  assign bus.bm_addr   = beat_addr;
  assign bus.bm_wdata  = beat_wdata;
  assign bus.resp      = '{mem_ready: ready_pulse, mem_data: resp_line};

  // Beat outputs are loaded one beat ahead so they are already stable when bm_valid rises.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      line_addr   <= '0;
      line_buf    <= '0;
      beat_valid  <= 1'b0;
      beat_we     <= 1'b0;
      beat_addr   <= '0;
      beat_wdata  <= '0;
      ready_pulse <= 1'b0;
      resp_line   <= '0;
    end else begin
      ready_pulse <= 1'b0;
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (bus.req.mem_req_store) begin
            state      <= WR_BEAT;
            line_addr  <= bus.req.mem_addr;
            line_buf   <= bus.req.mem_data_out;
            beat_valid <= 1'b1;
            beat_we    <= 1'b1;
            beat_addr  <= {bus.req.mem_addr, {OFFSET_BITS{1'b0}}};
            beat_wdata <= bus.req.mem_data_out[WIDTH-1:0];
          end else if (bus.req.mem_req_load) begin
            state      <= RD_REQ;
            line_addr  <= bus.req.mem_addr;
            beat_valid <= 1'b1;
            beat_we    <= 1'b0;
            beat_addr  <= {bus.req.mem_addr, {OFFSET_BITS{1'b0}}};
          end
        end
        WR_BEAT: begin
          if (accept) begin
            if (beat_cnt == LAST_BEAT) begin
              state       <= RESP;
              beat_valid  <= 1'b0;
              beat_we     <= 1'b0;
              ready_pulse <= 1'b1;
              resp_line   <= line_buf;
            end else begin
              beat_cnt   <= next_beat;
              beat_addr  <= {line_addr, next_beat, {BYTE_BITS{1'b0}}};
              beat_wdata <= line_buf[next_beat*WIDTH +: WIDTH];
            end
          end
        end
        RD_REQ: begin
          if (accept) begin
            state      <= RD_WAIT;
            beat_valid <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (bus.bm_rvalid) begin
            line_buf[beat_cnt*WIDTH +: WIDTH] <= bus.bm_rdata;
            if (beat_cnt == LAST_BEAT) begin
              // The final beat bypasses line_buf so the response lands in the same cycle.
              state       <= RESP;
              ready_pulse <= 1'b1;
              resp_line   <= line_buf;
              resp_line[beat_cnt*WIDTH +: WIDTH] <= bus.bm_rdata;
            end else begin
              state      <= RD_REQ;
              beat_cnt   <= next_beat;
              beat_valid <= 1'b1;
              beat_addr  <= {line_addr, next_beat, {BYTE_BITS{1'b0}}};
            end
          end
        end
        RESP: begin
          state    <= IDLE;
          beat_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LINE_BRIDGE_PERF_EN
  logic is_store;

  // Counts completed lines by kind and cycles where a beat is held back by the memory.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      is_store    <= 1'b0;
      perf_loads  <= '0;
      perf_stores <= '0;
      perf_stall  <= '0;
    end else begin
      if (state == IDLE) begin
        if (bus.req.mem_req_store) is_store <= 1'b1;
        else if (bus.req.mem_req_load) is_store <= 1'b0;
      end
      if (beat_valid && !bus.bm_ready) perf_stall <= perf_stall + 32'd1;
      if (state == RESP) begin
        if (is_store) perf_stores <= perf_stores + 32'd1;
        else perf_loads <= perf_loads + 32'd1;
      end
    end
  end
`endif
endmodule
